// File: rtl/imem_loader.sv
// imem_loader: parametrised instruction memory with a byte-serial program-load port and a registered fetch port.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_start_i           one-cycle request to (re)start a program load
//   ld_valid_i/ld_byte_i   program byte stream (little-endian within a word)
//   ld_last_i              marks the final program byte
//   ld_ready_o             a byte is accepted this cycle when ld_valid_i is high
//   ld_done_o              one-cycle pulse in the first RUN cycle after a load
//   ld_count_o             words written by the current/last load
//   fetch_req_i, pc_i      fetch request and byte address
//   inst_o, inst_valid_o   fetched instruction, valid one cycle after the request
//   addr_err_o             answered fetch was misaligned or out of range
module imem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic [ADDR_W:0]   ld_count_o,
  input  logic              fetch_req_i,
  input  logic [31:0]       pc_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              addr_err_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS = $clog2(BYTES);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BW = (OFS > 0) ? OFS : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
  state_e state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [DATA_W-1:0] asm_q, asm_d, wdata, inst_q;
  logic done_q, done_d, vld_q, err_q, we, accept, fire, bad;
  logic [ADDR_W-1:0] widx;
  logic [DATA_W-1:0] mem [DEPTH];
  // wptr counts written words, so it doubles as ld_count; its MSB set means wptr == DEPTH
  assign ld_ready_o = (state_q == LOAD) && !wptr_q[ADDR_W];
  assign ld_done_o = done_q;
  assign ld_count_o = wptr_q;
  assign inst_o = inst_q;
  assign inst_valid_o = vld_q;
  assign addr_err_o = err_q;
  assign accept = ld_valid_i && ld_ready_o;
  // merging the incoming byte into the assembly register; upper bytes are still zero
  assign wdata = asm_q | (DATA_W'(ld_byte_i) << {bidx_q, 3'b000});
  assign fire = (state_q == RUN) && fetch_req_i && !load_start_i;
  assign widx = ADDR_W'(pc_i >> OFS);
  assign bad = ((pc_i & 32'(BYTES - 1)) != 32'd0) || ((pc_i >> (OFS + ADDR_W)) != 32'd0);
  always_comb begin
    state_d = state_q;
    wptr_d = wptr_q;
    bidx_d = bidx_q;
    asm_d = asm_q;
    we = 1'b0;
    done_d = 1'b0;
    if (load_start_i) begin
      state_d = LOAD;
      wptr_d = '0;
      bidx_d = '0;
      asm_d = '0;
    end else if (accept) begin
      if (bidx_q == BW'(BYTES - 1) || ld_last_i) begin
        we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        bidx_d = '0;
        asm_d = '0;
        // filling the top word ends the load even without ld_last
        if (ld_last_i || &wptr_q[ADDR_W-1:0]) begin
          state_d = RUN;
          done_d = 1'b1;
        end
      end else begin
        bidx_d = bidx_q + 1'b1;
        asm_d = wdata;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q <= '0;
      bidx_q <= '0;
      asm_q <= '0;
      done_q <= 1'b0;
      inst_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      bidx_q <= bidx_d;
      asm_q <= asm_d;
      done_q <= done_d;
      vld_q <= fire;
      err_q <= fire && bad;
      if (fire) inst_q <= bad ? '0 : mem[widx];
    end
  end
  always_ff @(posedge clk_i) begin
    if (we) mem[wptr_q[ADDR_W-1:0]] <= wdata;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory for the single-cycle/multi-cycle CPU. It replaces the fixed 2048×32 read-only IMEM with a width- and depth-configurable array and adds a byte-serial program-load port with a ready/valid handshake, so a boot source (UART/testbench) can load the program after reset. Fetch is a registered read port with a one-cycle latency and a valid flag. Misaligned or out-of-range program counters are reported via an error flag instead of aliasing.

## Interface
Parameters:
- DATA_W, 32: instruction width in bits; must be a multiple of 8 (BYTES = DATA_W/8, a power of 2; OFS = log2(BYTES)).
- ADDR_W, 11: word-address width; DEPTH = 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to (re)start program load.
- ld_valid  in  1  ld_byte is valid this cycle.
- ld_byte  in  8  program byte, little-endian within a word.
- ld_last  in  1  qualifies the final byte of the program (meaningful only with ld_valid).
- ld_ready  out  1  block accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse: load finished, block is in RUN.
- ld_count  out  ADDR_W+1  number of words written by the current/last load.
- fetch_req  in  1  fetch request.
- pc  in  32  byte address of the fetch.
- inst  out  DATA_W  fetched instruction.
- inst_valid  out  1  inst is valid this cycle.
- addr_err  out  1  the fetch answered this cycle was misaligned or out of range.

## Operation
- States: IDLE (after reset), LOAD, RUN.
- IDLE: ld_ready=0; fetches are ignored. load_start -> LOAD.
- Entering LOAD: wptr=0, byte index=0, ld_count=0, assembly register cleared.
- LOAD: ld_ready=1 while wptr<DEPTH. A byte is accepted when ld_valid&&ld_ready. Byte k of a word lands in bits [8k+7:8k].
  - On acceptance of byte BYTES-1, mem[wptr] is written with the assembled word on that edge, then wptr++, ld_count++, and the byte index returns to 0.
  - ld_last on an accepted byte: the partial word is zero-padded in the upper bytes and written on the same edge, ld_count++, then -> RUN.
  - Writing word DEPTH-1 without ld_last is an implicit last: -> RUN.
  - load_start during LOAD restarts the load (wptr=0).
- RUN: fetches are served. load_start -> LOAD and takes priority over a same-cycle fetch_req, which is dropped.
- Fetch decode:
  - word index = pc[OFS+ADDR_W-1:OFS].
  - Misaligned: pc[OFS-1:0]≠0.
  - Out of range: pc[31:OFS+ADDR_W]≠0.
  - On either error: inst=0 (NOP), addr_err=1, and the memory is not read.
- fetch_req outside RUN: no response (inst_valid stays 0).
- Memory contents are not reset. Words past ld_count keep their old contents.

## Timing
- Reset values: state=IDLE, ld_ready=0, ld_done=0, ld_count=0, inst=0, inst_valid=0, addr_err=0.
- ld_ready is combinational from state and wptr. Gaps in ld_valid are allowed and leave the assembly register unchanged.
- ld_done is registered: it pulses for exactly one cycle, in the first cycle the block is in RUN after a load.
- A word written at edge N is readable by a fetch_req sampled at edge N+1 or later.
- Fetch latency is 1 cycle: fetch_req sampled at edge N gives inst, inst_valid=1 and addr_err in the cycle after edge N.
- Back-to-back fetches every cycle are supported.
- With no fetch, inst holds its last value, inst_valid=0 and addr_err=0.
- Reset asserted mid-load: immediate return to IDLE with all outputs at reset values. A partially assembled word is discarded.

## Test plan
- Reset, then drive fetch_req with pc=0 -> inst_valid stays 0, ld_ready=0, all outputs 0.
- load_start, then bytes 13 00 00 00 B3 00 21 00 with ld_last on the 8th -> ld_done pulses once and ld_count=2. Fetch pc=0 -> 0x00000013 after 1 cycle; pc=4 -> 0x002100B3.
- Load 6 bytes 01 02 03 04 AA BB with ld_last on BB, inserting 2-cycle ld_valid gaps -> ld_count=2 and pc=4 returns 0x0000BBAA. fetch_req issued during LOAD gets no response.
- In RUN: pc=2 -> inst=0 and addr_err=1; pc=0x2000 (ADDR_W=11) -> addr_err=1; pc=0x1FFC -> addr_err=0. Assert load_start with fetch_req in the same cycle -> no inst_valid, state LOAD.
- ADDR_W=3 instance: stream 32 bytes with no ld_last -> ld_ready drops after the 32nd byte, ld_done pulses, ld_count=8, and pc=28 returns the last word.
- Pull rst_n low after 3 bytes of a load -> immediate IDLE with ld_ready=0. A new load of 4 bytes then writes word 0 correctly, without stale bytes.
